// File: rtl/crg_job_scheduler.sv
// Round-robin job front end for the correlated random generator (CRG).
// Accepts one job at a time, programs the CRG and tracks returned beats.
module crg_job_scheduler #(
  parameter int NREQ      = 2,
  parameter int CNT_W     = 32,
  parameter int LATENCY   = 27,
  parameter int TMO_SLACK = 8,
  parameter int WIDTH_W   = 2,
  parameter int MODE_W    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_vld_i,
  output logic [NREQ-1:0]           req_rdy_o,
  input  logic [NREQ*CNT_W-1:0]     req_start_i,
  input  logic [NREQ*CNT_W-1:0]     req_len_i,
  input  logic [NREQ*WIDTH_W-1:0]   req_width_i,
  input  logic [NREQ*MODE_W-1:0]    req_mode_i,
  output logic [NREQ-1:0]           done_o,
  output logic [NREQ-1:0]           err_o,
  output logic                      crg_run_o,
  output logic [CNT_W-1:0]          crg_cnt_start_o,
  output logic [CNT_W-1:0]          crg_cnt_end_o,
  output logic [WIDTH_W-1:0]        crg_width_o,
  output logic [MODE_W-1:0]         crg_mode_o,
  input  logic                      crg_dvld_i,
  output logic                      out_vld_o,
  output logic [$clog2(NREQ)-1:0]   out_id_o,
  output logic                      busy_o
);

  localparam int ID_W = $clog2(NREQ);
  localparam int WD_W = $clog2(LATENCY + TMO_SLACK + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RUN} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr, owner, winner;
  logic               any_vld;
  logic [CNT_W-1:0]   len_r, beat_cnt;
  logic               job_ok;
  logic [WD_W-1:0]    wdog;
  logic [CNT_W-1:0]   sel_start, sel_len;
  logic [WIDTH_W-1:0] sel_width;
  logic [MODE_W-1:0]  sel_mode;
  logic [CNT_W:0]     sel_sum;
  logic               sel_ok;

  // Round-robin search: first requester at or above rr, then wrap to 0.
  always_comb begin
    any_vld = 1'b0;
    winner  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_vld && req_vld_i[i] && (ID_W'(i) >= rr)) begin
        any_vld = 1'b1;
        winner  = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any_vld && req_vld_i[i]) begin
        any_vld = 1'b1;
        winner  = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_start = '0;
    sel_len   = '0;
    sel_width = '0;
    sel_mode  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == winner) begin
        sel_start = req_start_i[i*CNT_W +: CNT_W];
        sel_len   = req_len_i[i*CNT_W +: CNT_W];
        sel_width = req_width_i[i*WIDTH_W +: WIDTH_W];
        sel_mode  = req_mode_i[i*MODE_W +: MODE_W];
      end
    end
  end

  // Validation is computed at accept so the CRG config is only loaded for good jobs.
  assign sel_sum = {1'b0, sel_start} + {1'b0, sel_len} - (CNT_W+1)'(1);
  assign sel_ok  = (sel_len != '0) && (sel_start != '0) && !sel_sum[CNT_W];

  always_comb begin
    state_nxt = state;
    req_rdy_o = '0;
    done_o    = '0;
    err_o     = '0;
    crg_run_o = 1'b0;
    out_vld_o = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld && !rst_i) begin
          req_rdy_o[winner] = 1'b1;
          state_nxt         = GRANT;
        end
      end
      GRANT: begin
        if (job_ok) begin
          crg_run_o = 1'b1;
          state_nxt = RUN;
        end else begin
          err_o[owner] = 1'b1;
          state_nxt    = IDLE;
        end
      end
      RUN: begin
        out_vld_o = crg_dvld_i;
        if (crg_dvld_i && (beat_cnt == len_r - CNT_W'(1))) begin
          done_o[owner] = 1'b1;
          state_nxt     = IDLE;
        end else if (!crg_dvld_i && (wdog == WD_W'(1))) begin
          err_o[owner] = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      rr              <= '0;
      owner           <= '0;
      len_r           <= '0;
      job_ok          <= 1'b0;
      beat_cnt        <= '0;
      wdog            <= '0;
      crg_cnt_start_o <= '0;
      crg_cnt_end_o   <= '0;
      crg_width_o     <= '0;
      crg_mode_o      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_vld) begin
            owner  <= winner;
            len_r  <= sel_len;
            job_ok <= sel_ok;
            rr     <= (winner == ID_W'(NREQ-1)) ? '0 : winner + ID_W'(1);
            if (sel_ok) begin
              crg_cnt_start_o <= sel_start;
              crg_cnt_end_o   <= sel_sum[CNT_W-1:0];
              crg_width_o     <= sel_width;
              crg_mode_o      <= sel_mode;
            end
          end
        end
        GRANT: begin
          beat_cnt <= '0;
          wdog     <= WD_W'(LATENCY + TMO_SLACK);
        end
        RUN: begin
          // Each beat re-arms the watchdog with the shorter inter-beat slack.
          if (crg_dvld_i) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            wdog     <= WD_W'(TMO_SLACK);
          end else begin
            wdog <= wdog - WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_id_o = owner;
  assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_crg_job_scheduler.sv
// Self-checking bench for crg_job_scheduler: job table, CRG beat model and
// a scoreboard of expected output beats.
module tb_crg_job_scheduler;

  localparam int LAT = 27;
  localparam int SLK = 8;

  typedef struct {
    int          id;
    logic [31:0] start;
    logic [31:0] len;
    logic [1:0]  width;
    logic        mode;
    bit          ok;
    logic [31:0] cend;
    bit          tmo;
  } job_t;

  typedef struct {
    int id;
    bit last;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_vld_i;
  logic [1:0]  req_rdy_o;
  logic [63:0] req_start_i;
  logic [63:0] req_len_i;
  logic [3:0]  req_width_i;
  logic [1:0]  req_mode_i;
  logic [1:0]  done_o;
  logic [1:0]  err_o;
  logic        crg_run_o;
  logic [31:0] crg_cnt_start_o;
  logic [31:0] crg_cnt_end_o;
  logic [1:0]  crg_width_o;
  logic [0:0]  crg_mode_o;
  logic        crg_dvld_i;
  logic        out_vld_o;
  logic [0:0]  out_id_o;
  logic        busy_o;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t sb[$];
  int    model_len = 0;
  bit    suppress  = 1'b0;
  bit    stray     = 1'b0;
  job_t  jobs[9];

  crg_job_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
    .req_start_i(req_start_i), .req_len_i(req_len_i),
    .req_width_i(req_width_i), .req_mode_i(req_mode_i),
    .done_o(done_o), .err_o(err_o),
    .crg_run_o(crg_run_o), .crg_cnt_start_o(crg_cnt_start_o),
    .crg_cnt_end_o(crg_cnt_end_o), .crg_width_o(crg_width_o),
    .crg_mode_o(crg_mode_o), .crg_dvld_i(crg_dvld_i),
    .out_vld_o(out_vld_o), .out_id_o(out_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [1:0] onehot(input int id);
    onehot = 2'b01 << id;
  endfunction

  function automatic job_t mk(input int id, input logic [31:0] s, input logic [31:0] l,
                              input logic [1:0] w, input logic m, input bit ok,
                              input logic [31:0] ce, input bit tmo);
    job_t j;
    j.id = id; j.start = s; j.len = l; j.width = w; j.mode = m;
    j.ok = ok; j.cend = ce; j.tmo = tmo;
    return j;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic driveReq(input job_t j);
    if (j.id == 0) begin
      req_start_i[31:0] = j.start;
      req_len_i[31:0]   = j.len;
      req_width_i[1:0]  = j.width;
      req_mode_i[0]     = j.mode;
    end else begin
      req_start_i[63:32] = j.start;
      req_len_i[63:32]   = j.len;
      req_width_i[3:2]   = j.width;
      req_mode_i[1]      = j.mode;
    end
    req_vld_i = req_vld_i | onehot(j.id);
  endtask

  // Raise the request and wait (bounded) until it is the one granted.
  task automatic applyStimulus(input job_t j, output bit acc);
    acc = 1'b0;
    driveReq(j);
    model_len = int'(j.len);
    suppress  = j.tmo;
    #1;
    for (int c = 0; c < 80; c++) begin
      if (req_rdy_o != 2'b00) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checkOutput("req_rdy", 64'(req_rdy_o), 64'(onehot(j.id)));
    if (acc) begin
      @(posedge clk_i);
      #1;
    end
    req_vld_i = req_vld_i & ~onehot(j.id);
  endtask

  // Check the GRANT cycle, then follow the job until done/err (bounded).
  task automatic waitJob(input job_t j);
    int k;
    bit seen;
    @(negedge clk_i);
    checkOutput("grant_busy", 64'(busy_o), 64'(1));
    checkOutput("grant_run", 64'(crg_run_o), 64'(j.ok));
    checkOutput("grant_err", 64'(err_o), 64'(j.ok ? 2'b00 : onehot(j.id)));
    checkOutput("grant_done", 64'(done_o), 64'(0));
    if (!j.ok) begin
      @(negedge clk_i);
      checkOutput("reject_idle", 64'(busy_o), 64'(0));
      checkOutput("reject_err_clear", 64'(err_o), 64'(0));
      checkOutput("reject_no_run", 64'(crg_run_o), 64'(0));
      return;
    end
    checkOutput("cnt_start", 64'(crg_cnt_start_o), 64'(j.start));
    checkOutput("cnt_end", 64'(crg_cnt_end_o), 64'(j.cend));
    checkOutput("cfg_width", 64'(crg_width_o), 64'(j.width));
    checkOutput("cfg_mode", 64'(crg_mode_o), 64'(j.mode));
    if (!j.tmo)
      for (int b = 0; b < int'(j.len); b++) sb.push_back('{j.id, b == int'(j.len) - 1});
    seen = 1'b0;
    for (k = 1; k <= LAT + SLK + int'(j.len) + 5; k++) begin
      @(negedge clk_i);
      if (k == 1) checkOutput("run_one_cycle", 64'(crg_run_o), 64'(0));
      if (out_vld_o) begin
        checkOutput("beat_width", 64'(crg_width_o), 64'(j.width));
        checkOutput("beat_mode", 64'(crg_mode_o), 64'(j.mode));
        checkOutput("beat_cnt_end", 64'(crg_cnt_end_o), 64'(j.cend));
      end
      if ((done_o | err_o) != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    if (j.tmo) begin
      checkOutput("tmo_cycle", 64'(k), 64'(LAT + SLK));
      checkOutput("tmo_err", 64'(err_o), 64'(onehot(j.id)));
      checkOutput("tmo_no_done", 64'(done_o), 64'(0));
    end else begin
      checkOutput("done_cycle", 64'(k), 64'(LAT + int'(j.len) - 1));
      checkOutput("done_pulse", 64'(done_o), 64'(onehot(j.id)));
      checkOutput("done_no_err", 64'(err_o), 64'(0));
    end
    if (seen) begin
      @(negedge clk_i);
      checkOutput("end_idle", 64'(busy_o), 64'(0));
      checkOutput("end_width_held", 64'(crg_width_o), 64'(j.width));
    end
  endtask

  // CRG model: beats start LAT cycles after the run pulse, one per cycle.
  initial begin
    int cyc, first_beat, n_beats;
    cyc = 0; first_beat = 0; n_beats = 0;
    crg_dvld_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (crg_run_o) begin
        first_beat = cyc + LAT;
        n_beats    = model_len;
      end
      crg_dvld_i = (!suppress && cyc >= first_beat && cyc < first_beat + n_beats) || stray;
    end
  end

  // Scoreboard: every output beat must match the next expected entry.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk_i);
      if (out_vld_o === 1'b1) begin
        if (sb.size() == 0) checkOutput("sb_unexpected_beat", 64'(out_vld_o), 64'(0));
        else begin
          e = sb.pop_front();
          checkOutput("sb_id", 64'(out_id_o), 64'(e.id));
          checkOutput("sb_done", 64'(done_o), 64'(e.last ? onehot(e.id) : 2'b00));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    job_t c0, c1, jr, jf;
    bit   acc;

    jobs[0] = mk(0, 32'd1,          32'd4, 2'd0, 1'b0, 1'b1, 32'd4,          1'b0);
    jobs[1] = mk(1, 32'd0,          32'd5, 2'd1, 1'b0, 1'b0, 32'd0,          1'b0);
    jobs[2] = mk(0, 32'd7,          32'd0, 2'd1, 1'b0, 1'b0, 32'd0,          1'b0);
    jobs[3] = mk(1, 32'hFFFF_FFFE,  32'd4, 2'd1, 1'b0, 1'b0, 32'd0,          1'b0);
    jobs[4] = mk(0, 32'hFFFF_FFFE,  32'd2, 2'd3, 1'b1, 1'b1, 32'hFFFF_FFFF,  1'b0);
    jobs[5] = mk(1, 32'd3,          32'd3, 2'd2, 1'b0, 1'b1, 32'd5,          1'b1);
    jobs[6] = mk(0, 32'd9,          32'd2, 2'd0, 1'b0, 1'b1, 32'd10,         1'b0);
    jobs[7] = mk(1, 32'd10,         32'd3, 2'd1, 1'b1, 1'b1, 32'd12,         1'b0);
    jobs[8] = mk(0, 32'd20,         32'd3, 2'd2, 1'b0, 1'b1, 32'd22,         1'b0);

    rst_i = 1'b1;
    req_vld_i = '0; req_start_i = '0; req_len_i = '0; req_width_i = '0; req_mode_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_busy", 64'(busy_o), 64'(0));
    checkOutput("rst_run", 64'(crg_run_o), 64'(0));
    checkOutput("rst_rdy", 64'(req_rdy_o), 64'(0));
    checkOutput("rst_cnt_end", 64'(crg_cnt_end_o), 64'(0));
    checkOutput("rst_out_vld", 64'(out_vld_o), 64'(0));
    rst_i = 1'b0;
    @(negedge clk_i);

    // Contention from reset (rr=0): order 0,1 then again 0,1.
    c0 = mk(0, 32'd5,  32'd2, 2'd0, 1'b0, 1'b1, 32'd6,  1'b0);
    c1 = mk(1, 32'd50, 32'd2, 2'd3, 1'b1, 1'b1, 32'd51, 1'b0);
    for (int r = 0; r < 2; r++) begin
      driveReq(c0);
      driveReq(c1);
      applyStimulus(c0, acc);
      if (acc) waitJob(c0);
      applyStimulus(c1, acc);
      if (acc) waitJob(c1);
    end

    // Stray dvld while idle is ignored.
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("stray_out_vld", 64'(out_vld_o), 64'(0));
      checkOutput("stray_busy", 64'(busy_o), 64'(0));
    end
    stray = 1'b0;
    repeat (2) @(negedge clk_i);

    for (int t = 0; t < 9; t++) begin
      applyStimulus(jobs[t], acc);
      if (acc) waitJob(jobs[t]);
    end

    // Reset after two of eight beats.
    jr = mk(0, 32'd100, 32'd8, 2'd3, 1'b1, 1'b1, 32'd107, 1'b0);
    applyStimulus(jr, acc);
    @(negedge clk_i);
    checkOutput("rstrun_grant_run", 64'(crg_run_o), 64'(1));
    sb.push_back('{0, 1'b0});
    sb.push_back('{0, 1'b0});
    repeat (LAT + 1) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rstrun_busy", 64'(busy_o), 64'(0));
    checkOutput("rstrun_out_vld", 64'(out_vld_o), 64'(0));
    checkOutput("rstrun_done", 64'(done_o), 64'(0));
    checkOutput("rstrun_err", 64'(err_o), 64'(0));
    checkOutput("rstrun_cnt_start", 64'(crg_cnt_start_o), 64'(0));
    checkOutput("rstrun_cnt_end", 64'(crg_cnt_end_o), 64'(0));
    checkOutput("rstrun_width", 64'(crg_width_o), 64'(0));
    checkOutput("rstrun_mode", 64'(crg_mode_o), 64'(0));
    checkOutput("rstrun_out_id", 64'(out_id_o), 64'(0));
    rst_i = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      checkOutput("leftover_out_vld", 64'(out_vld_o), 64'(0));
      checkOutput("leftover_pulses", 64'(done_o | err_o), 64'(0));
    end

    jf = mk(1, 32'd40, 32'd2, 2'd1, 1'b0, 1'b1, 32'd41, 1'b0);
    applyStimulus(jf, acc);
    if (acc) waitJob(jf);

    repeat (5) @(negedge clk_i);
    checkOutput("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crg_job_scheduler.md
Name: crg_job_scheduler

Overview:
- Front-end controller for the correlated random generator (CRG).
- Accepts generation jobs from NREQ requesters, arbitrates among them round-robin, and programs the CRG: cnt_start/cnt_end, width and mode, plus a one-cycle run pulse.
- Counts returned dvld beats so it knows when a job is complete. Tags each output beat with the owner's ID and signals per-requester completion.
- Exactly one job is in flight at a time. Configuration is held stable until the last beat of the job drains from the CRG pipeline.

Parameters:
- NREQ, 2: number of requesters (2..8).
- CNT_W, 32: width of cr_cnt_t, the counter/index width.
- LATENCY, 27: CRG run-to-first-dvld latency; used for the watchdog.
- TMO_SLACK, 8: extra cycles allowed beyond LATENCY before the watchdog fires.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_vld_i  in  NREQ  per-requester job request valid.
- req_rdy_o  out  NREQ  per-requester accept; a job is accepted when vld&rdy.
- req_start_i  in  NREQ*CNT_W  first counter value of the job.
- req_len_i  in  NREQ*CNT_W  number of output triples in the job.
- req_width_i  in  NREQ*width_t  SIMD lane width for the job.
- req_mode_i  in  NREQ*mode_t  arithmetic/boolean mode for the job.
- done_o  out  NREQ  one-cycle pulse to the owner when the job completes.
- err_o  out  NREQ  one-cycle pulse to the owner when the job is rejected or times out.
- crg_run_o  out  1  run pulse to the CRG.
- crg_cnt_start_o  out  CNT_W  to CRG cnt_start_i.
- crg_cnt_end_o  out  CNT_W  to CRG cnt_end_i.
- crg_width_o  out  width_t  to CRG width_i.
- crg_mode_o  out  mode_t  to CRG mode_i.
- crg_dvld_i  in  1  from CRG dvld_o.
- out_vld_o  out  1  equals crg_dvld_i while in RUN.
- out_id_o  out  $clog2(NREQ)  owner ID of the current beat.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset:
- rst_i forces IDLE on the next clock edge.
- All outputs reset to 0, the round-robin pointer resets to 0, and the beat counter resets to 0.
- Reset mid-job abandons the job silently; no done or err pulse is issued.

FSM states: IDLE -> GRANT -> RUN -> IDLE; also GRANT -> IDLE on reject, and RUN -> IDLE on timeout.

IDLE:
- If any req_vld_i is high, select the winner round-robin, starting from pointer rr and searching upward with wrap.
- Assert req_rdy_o[winner] for one cycle, combinationally in that same cycle. Latch start, len, width, mode and the owner ID.
- Set rr = winner+1 mod NREQ.
- Go to GRANT.
- req_rdy_o is 0 in all other states.

GRANT (one cycle): validate the latched job.
- Reject if len==0, start==0 (the CRG treats a zero counter as idle), or start+len-1 overflows CNT_W.
- On reject: pulse err_o[owner] and go to IDLE, with no crg_run_o.
- Otherwise: drive crg_cnt_end_o = start+len-1 and crg_cnt_start_o = start, pulse crg_run_o for exactly one cycle, clear beat_cnt, load the watchdog, and go to RUN.

CRG configuration hold:
- crg_width_o, crg_mode_o, crg_cnt_start_o and crg_cnt_end_o are registered.
- They remain constant from GRANT until the cycle after the final beat.
- After that they hold their last value; they are not cleared.

RUN:
- Each cycle with crg_dvld_i=1: increment beat_cnt and assert out_vld_o with out_id_o=owner.
- When beat_cnt reaches len-1 and crg_dvld_i=1 (the last beat): pulse done_o[owner] in that same cycle and go to IDLE next cycle.
- Expected beats: exactly len, on consecutive cycles.

Watchdog:
- Preloaded to LATENCY+TMO_SLACK at GRANT.
- Decrements every RUN cycle.
- Reloads to TMO_SLACK on every dvld beat.
- On reaching 0: pulse err_o[owner] and go to IDLE.

Other rules:
- Stray crg_dvld_i while in IDLE or GRANT is ignored, and out_vld_o stays 0.
- Requests arriving during a job wait; req_vld_i must be held by the requester until accepted.
- Simultaneous requests are resolved purely by the rr pointer.
- done_o and err_o are never both asserted for the same job.
- Back-to-back jobs have a minimum gap of 2 cycles between the last beat of one job and the run pulse of the next (RUN->IDLE, IDLE->GRANT).

Test Plan:
1. Single job: req0 with start=1, len=4.
   - Required: one run pulse, cnt_end=4.
   - CRG model returns 4 dvld beats starting 27 cycles later, out_id=0 on each.
   - done_o[0] pulses with the 4th beat; busy_o drops the next cycle.
2. Contention: req0 and req1 both valid from reset with rr=0, each with len=2.
   - Required grant order: 0, then 1. Repeat the pair: order 0, 1 again.
   - With req1 alone valid while rr=1: req1 is granted.
3. Reject cases, each giving err_o[owner] with no crg_run_o and an immediate return to IDLE:
   - start=0, len=5.
   - len=0.
   - start=0xFFFF_FFFE, len=4 (overflow).
4. Timeout: CRG model with dvld suppressed.
   - Required: err_o pulses 35 cycles after the run pulse (27+8); no done_o.
   - A follow-up job succeeds normally.
5. Reset mid-RUN: rst_i asserted after 2 of 8 beats.
   - Required: next cycle all outputs are 0 and the FSM is in IDLE.
   - Leftover dvld beats produce no out_vld_o and no done_o or err_o.
6. Config stability: job with width=W1, mode=boolean, then a job with W2/arith.
   - Required: crg_width_o and crg_mode_o stay constant across every beat of job 1 and change only at job 2's GRANT.
